// File: rtl/tz_access_arbiter.sv
// tz_access_arbiter: shares one peripheral write port between a secure and a
// non-secure master. Every forwarded write carries its true security tag, and a
// secure-owned lock turns non-secure requests into counted rejections.
module tz_access_arbiter #(
  parameter int DW          = 32,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_req,
  input  logic [DW-1:0]    s_data,
  output logic             s_gnt,
  input  logic             ns_req,
  input  logic [DW-1:0]    ns_data,
  output logic             ns_gnt,
  output logic             ns_err,
  input  logic             lock_set,
  input  logic             lock_clr,
  output logic             lock,
  output logic             per_valid,
  output logic [DW-1:0]    per_data,
  output logic             per_ns,
  output logic [CNT_W-1:0] viol_count
);

  // The hold counter runs HOLD_CYCLES-1 down to 0, so 4 bits cover 1..15.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    REJECT
  } state_t;

  state_t           state, state_next;
  logic             last_ns, last_ns_next;
  logic [3:0]       hold_cnt, hold_cnt_next;
  logic             lock_next;
  logic             s_gnt_next, ns_gnt_next, ns_err_next;
  logic             per_valid_next, per_ns_next;
  logic [DW-1:0]    per_data_next;
  logic [CNT_W-1:0] viol_next;
  logic             win_ns;

  // State and output registers: every output is a flop, no input-to-output paths.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      state      <= IDLE;
      last_ns    <= 1'b1;
      hold_cnt   <= '0;
      lock       <= 1'b0;
      s_gnt      <= 1'b0;
      ns_gnt     <= 1'b0;
      ns_err     <= 1'b0;
      per_valid  <= 1'b0;
      per_ns     <= 1'b0;
      per_data   <= '0;
      viol_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      state      <= state_next;
      last_ns    <= last_ns_next;
      hold_cnt   <= hold_cnt_next;
      lock       <= lock_next;
      s_gnt      <= s_gnt_next;
      ns_gnt     <= ns_gnt_next;
      ns_err     <= ns_err_next;
      per_valid  <= per_valid_next;
      per_ns     <= per_ns_next;
      per_data   <= per_data_next;
      viol_count <= viol_next;
    end
  end

  // Arbitration, transfer sequencing and next-value computation for all outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next     = state;
    last_ns_next   = last_ns;
    hold_cnt_next  = hold_cnt;
    per_data_next  = per_data;
    per_ns_next    = per_ns;
    per_valid_next = 1'b0;
    s_gnt_next     = 1'b0;
    ns_gnt_next    = 1'b0;
    ns_err_next    = 1'b0;
    viol_next      = viol_count;
    win_ns         = 1'b0;

    // Set has priority; the decision below uses the registered lock only, so a
    // set arriving with a request does not apply to that request.
    lock_next = lock_set ? 1'b1 : (lock_clr ? 1'b0 : lock);

    case (state)
      IDLE: begin
        if (s_req || ns_req) begin
          if (s_req && ns_req) begin
            // Locked ties always go secure; otherwise serve the side not served last.
            win_ns = lock ? 1'b0 : ~last_ns;
          end else begin
            win_ns = ns_req;
          end

          if (win_ns && lock) begin
            // Refused non-secure write: tag/data/round-robin history untouched.
            state_next  = REJECT;
            ns_gnt_next = 1'b1;
            ns_err_next = 1'b1;
            if (viol_count != {CNT_W{1'b1}}) begin
              viol_next = viol_count + 1'b1;
            end
          end else begin
            state_next     = XFER;
            per_data_next  = win_ns ? ns_data : s_data;
            per_ns_next    = win_ns;
            last_ns_next   = win_ns;
            hold_cnt_next  = HOLD_LOAD;
            per_valid_next = 1'b1;
            s_gnt_next     = ~win_ns;
            ns_gnt_next    = win_ns;
          end
        end
      end

      XFER: begin
        // Keep the strobe up until the counter has expired.
        if (hold_cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next  = hold_cnt - 4'd1;
          per_valid_next = 1'b1;
        end
      end

      REJECT: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tz_access_arbiter.sv
// Bench for tz_access_arbiter: a cycle table on a HOLD_CYCLES=1 / CNT_W=2
// instance, hand sequences for a HOLD_CYCLES=4 instance, then random traffic on
// both compared against a cycles-remaining reference model.
module tb_tz_access_arbiter;

  typedef struct packed {
    logic        rst_n;
    logic        s_req;
    logic [31:0] s_data;
    logic        ns_req;
    logic [31:0] ns_data;
    logic        lset;
    logic        lclr;
  } in_t;

  typedef struct packed {
    logic        sg;
    logic        ng;
    logic        err;
    logic        lk;
    logic        v;
    logic        pns;
    logic [7:0]  viol;
    logic [31:0] pdata;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  // Reference model state: how many more edges the current activity lasts.
  typedef struct packed {
    int   remain;
    bit   last_ns;
    out_t o;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_req = 1'b0;
  logic [31:0] s_data = '0;
  logic        ns_req = 1'b0;
  logic [31:0] ns_data = '0;
  logic        lock_set = 1'b0;
  logic        lock_clr = 1'b0;

  logic        s_gnt1, ns_gnt1, ns_err1, lock1, per_valid1, per_ns1;
  logic [31:0] per_data1;
  logic [1:0]  viol1;
  logic        s_gnt4, ns_gnt4, ns_err4, lock4, per_valid4, per_ns4;
  logic [31:0] per_data4;
  logic [7:0]  viol4;

  int   n_tests = 0;
  int   n_fail = 0;
  mdl_t m1, m4;
  vec_t tbl[$];

  always #5 clk = ~clk;

  tz_access_arbiter #(.DW(32), .HOLD_CYCLES(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .s_req(s_req), .s_data(s_data), .s_gnt(s_gnt1),
    .ns_req(ns_req), .ns_data(ns_data), .ns_gnt(ns_gnt1), .ns_err(ns_err1),
    .lock_set(lock_set), .lock_clr(lock_clr), .lock(lock1),
    .per_valid(per_valid1), .per_data(per_data1), .per_ns(per_ns1),
    .viol_count(viol1)
  );

  tz_access_arbiter #(.DW(32), .HOLD_CYCLES(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n),
    .s_req(s_req), .s_data(s_data), .s_gnt(s_gnt4),
    .ns_req(ns_req), .ns_data(ns_data), .ns_gnt(ns_gnt4), .ns_err(ns_err4),
    .lock_set(lock_set), .lock_clr(lock_clr), .lock(lock4),
    .per_valid(per_valid4), .per_data(per_data4), .per_ns(per_ns4),
    .viol_count(viol4)
  );

  function automatic in_t inp(bit r, bit sq, logic [31:0] sd, bit nq, logic [31:0] nd,
                              bit ls, bit lc);
    in_t x;
    x.rst_n = r; x.s_req = sq; x.s_data = sd; x.ns_req = nq; x.ns_data = nd;
    x.lset = ls; x.lclr = lc;
    return x;
  endfunction

  function automatic out_t ex(bit sg, bit ng, bit er, bit lk, bit v, bit pns,
                              logic [7:0] vi, logic [31:0] pd);
    out_t o;
    o.sg = sg; o.ng = ng; o.err = er; o.lk = lk; o.v = v; o.pns = pns;
    o.viol = vi; o.pdata = pd;
    return o;
  endfunction

  function automatic vec_t mk(in_t x, out_t o);
    vec_t r;
    r.in = x;
    r.exp = o;
    return r;
  endfunction

  function automatic out_t get1();
    return ex(s_gnt1, ns_gnt1, ns_err1, lock1, per_valid1, per_ns1, 8'(viol1), per_data1);
  endfunction

  function automatic out_t get4();
    return ex(s_gnt4, ns_gnt4, ns_err4, lock4, per_valid4, per_ns4, viol4, per_data4);
  endfunction

  // One clock edge of the arbiter, derived directly from the behavioural rules.
  function automatic mdl_t model_step(mdl_t m, in_t x, int hold, int vmax);
    mdl_t n = m;
    bit   win_ns;
    if (!x.rst_n) begin
      n = '0;
      n.last_ns = 1'b1;
      return n;
    end
    n.o.lk  = x.lset ? 1'b1 : (x.lclr ? 1'b0 : m.o.lk);
    n.o.sg  = 1'b0;
    n.o.ng  = 1'b0;
    n.o.err = 1'b0;
    if (m.remain > 0) begin
      n.remain = m.remain - 1;
      if (n.remain == 0) n.o.v = 1'b0;
    end else if (x.s_req || x.ns_req) begin
      if (x.s_req && x.ns_req) win_ns = m.o.lk ? 1'b0 : !m.last_ns;
      else win_ns = x.ns_req;
      if (win_ns && m.o.lk) begin
        n.remain = 1;
        n.o.ng   = 1'b1;
        n.o.err  = 1'b1;
        if (int'(m.o.viol) < vmax) n.o.viol = m.o.viol + 8'd1;
      end else begin
        n.remain  = hold;
        n.o.v     = 1'b1;
        n.o.pdata = win_ns ? x.ns_data : x.s_data;
        n.o.pns   = win_ns;
        n.last_ns = win_ns;
        if (win_ns) n.o.ng = 1'b1;
        else n.o.sg = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sg=%b ng=%b err=%b lock=%b valid=%b ns=%b viol=%0d data=%h, want sg=%b ng=%b err=%b lock=%b valid=%b ns=%b viol=%0d data=%h",
               name, act.sg, act.ng, act.err, act.lk, act.v, act.pns, act.viol, act.pdata,
               exp.sg, exp.ng, exp.err, exp.lk, exp.v, exp.pns, exp.viol, exp.pdata);
    end
  endtask

  // Called at a falling edge: apply inputs, advance both models, and return at
  // the next falling edge with the post-edge outputs settled.
  task automatic step(input in_t x);
    rst_n    = x.rst_n;
    s_req    = x.s_req;
    s_data   = x.s_data;
    ns_req   = x.ns_req;
    ns_data  = x.ns_data;
    lock_set = x.lset;
    lock_clr = x.lclr;
    m1 = model_step(m1, x, 1, 3);
    m4 = model_step(m4, x, 4, 255);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    in_t idle = inp(1, 0, 0, 0, 0, 0, 0);
    in_t both_a = inp(1, 1, 32'h1111_1111, 1, 32'h2222_2222, 0, 0);
    in_t both_b = inp(1, 1, 32'h4444_4444, 1, 32'h5555_5555, 0, 0);
    in_t rej = inp(1, 0, 0, 1, 32'h6666_6666, 0, 0);

    m1 = '0; m1.last_ns = 1'b1;
    m4 = '0; m4.last_ns = 1'b1;

    // Cycle table for the HOLD_CYCLES=1, CNT_W=2 instance.
    tbl.push_back(mk(inp(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    // Single secure write.
    tbl.push_back(mk(inp(1, 1, 32'hA5A5_0001, 0, 0, 0, 0), ex(1, 0, 0, 0, 1, 0, 0, 32'hA5A5_0001)));
    tbl.push_back(mk(inp(1, 1, 32'hA5A5_0001, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 32'hA5A5_0001)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 0, 0, 0, 0, 32'hA5A5_0001)));
    // Round-robin from reset: S, NS, S, NS, two cycles apart.
    tbl.push_back(mk(inp(0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(both_a, ex(1, 0, 0, 0, 1, 0, 0, 32'h1111_1111)));
    tbl.push_back(mk(both_a, ex(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111)));
    tbl.push_back(mk(both_a, ex(0, 1, 0, 0, 1, 1, 0, 32'h2222_2222)));
    tbl.push_back(mk(both_a, ex(0, 0, 0, 0, 0, 1, 0, 32'h2222_2222)));
    tbl.push_back(mk(both_a, ex(1, 0, 0, 0, 1, 0, 0, 32'h1111_1111)));
    tbl.push_back(mk(both_a, ex(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111)));
    tbl.push_back(mk(both_a, ex(0, 1, 0, 0, 1, 1, 0, 32'h2222_2222)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 0, 0, 1, 0, 32'h2222_2222)));
    // Lock, rejected non-secure write, unlock, accepted non-secure write.
    tbl.push_back(mk(inp(1, 0, 0, 0, 0, 1, 0), ex(0, 0, 0, 1, 0, 1, 0, 32'h2222_2222)));
    tbl.push_back(mk(inp(1, 0, 0, 1, 32'hDEAD_BEEF, 0, 0), ex(0, 1, 1, 1, 0, 1, 1, 32'h2222_2222)));
    tbl.push_back(mk(inp(1, 0, 0, 1, 32'hDEAD_BEEF, 0, 0), ex(0, 0, 0, 1, 0, 1, 1, 32'h2222_2222)));
    tbl.push_back(mk(inp(1, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1, 1, 32'h2222_2222)));
    tbl.push_back(mk(inp(1, 0, 0, 1, 32'h3333_3333, 0, 0), ex(0, 1, 0, 0, 1, 1, 1, 32'h3333_3333)));
    tbl.push_back(mk(inp(1, 0, 0, 0, 0, 1, 0), ex(0, 0, 0, 1, 0, 1, 1, 32'h3333_3333)));
    // Locked tie: secure wins twice in a row.
    tbl.push_back(mk(both_b, ex(1, 0, 0, 1, 1, 0, 1, 32'h4444_4444)));
    tbl.push_back(mk(both_b, ex(0, 0, 0, 1, 0, 0, 1, 32'h4444_4444)));
    tbl.push_back(mk(both_b, ex(1, 0, 0, 1, 1, 0, 1, 32'h4444_4444)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 1, 0, 0, 1, 32'h4444_4444)));
    // Four more rejections: 2-bit counter saturates at 3.
    tbl.push_back(mk(rej, ex(0, 1, 1, 1, 0, 0, 2, 32'h4444_4444)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 1, 0, 0, 2, 32'h4444_4444)));
    tbl.push_back(mk(rej, ex(0, 1, 1, 1, 0, 0, 3, 32'h4444_4444)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 1, 0, 0, 3, 32'h4444_4444)));
    tbl.push_back(mk(rej, ex(0, 1, 1, 1, 0, 0, 3, 32'h4444_4444)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 1, 0, 0, 3, 32'h4444_4444)));
    tbl.push_back(mk(rej, ex(0, 1, 1, 1, 0, 0, 3, 32'h4444_4444)));
    tbl.push_back(mk(idle, ex(0, 0, 0, 1, 0, 0, 3, 32'h4444_4444)));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].in);
      check($sformatf("table_row_%0d", i), get1(), tbl[i].exp);
    end

    // HOLD_CYCLES=4: strobe high for exactly four cycles, grant only in the first.
    step(inp(0, 0, 0, 0, 0, 0, 0));
    check("hold4_reset", get4(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    step(inp(1, 1, 32'hCAFE_0004, 0, 0, 0, 0));
    check("hold4_cycle1", get4(), ex(1, 0, 0, 0, 1, 0, 0, 32'hCAFE_0004));
    step(inp(1, 1, 32'hCAFE_0004, 0, 0, 0, 0));
    check("hold4_cycle2", get4(), ex(0, 0, 0, 0, 1, 0, 0, 32'hCAFE_0004));
    step(idle);
    check("hold4_cycle3", get4(), ex(0, 0, 0, 0, 1, 0, 0, 32'hCAFE_0004));
    step(idle);
    check("hold4_cycle4", get4(), ex(0, 0, 0, 0, 1, 0, 0, 32'hCAFE_0004));
    step(idle);
    check("hold4_done", get4(), ex(0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0004));

    // Reset asserted in the second transfer cycle abandons it and clears the lock.
    step(inp(1, 0, 0, 0, 0, 1, 0));
    check("midrst_locked", get4(), ex(0, 0, 0, 1, 0, 0, 0, 32'hCAFE_0004));
    step(inp(1, 1, 32'hBEEF_0005, 0, 0, 0, 0));
    check("midrst_cycle1", get4(), ex(1, 0, 0, 1, 1, 0, 0, 32'hBEEF_0005));
    step(inp(1, 1, 32'hBEEF_0005, 0, 0, 0, 0));
    check("midrst_cycle2", get4(), ex(0, 0, 0, 1, 1, 0, 0, 32'hBEEF_0005));
    step(inp(0, 0, 0, 0, 0, 0, 0));
    check("midrst_cleared", get4(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic against the reference model on both instances.
    for (int k = 0; k < 3000; k++) begin
      in_t x;
      x.rst_n   = ($urandom_range(0, 299) != 0);
      x.s_req   = ($urandom_range(0, 2) != 0);
      x.s_data  = $urandom;
      x.ns_req  = ($urandom_range(0, 2) != 0);
      x.ns_data = $urandom;
      x.lset    = ($urandom_range(0, 11) == 0);
      x.lclr    = ($urandom_range(0, 11) == 0);
      step(x);
      check($sformatf("rand_h1_%0d", k), get1(), m1.o);
      check($sformatf("rand_h4_%0d", k), get4(), m4.o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tz_access_arbiter.md
# tz_access_arbiter

Two-requester arbiter that shares a single TrustZone-style peripheral write port between a secure master and a non-secure master. Each winning transfer is forwarded with an explicit security tag, never tied off, so the peripheral always sees the true origin of its data. A secure-controlled lock rejects non-secure writes. Rejections are flagged to the requester and counted. The block sits between the bus masters and the peripheral's `data_in` / `data_in_security_level` pins.

## Interface
- `DW`, default 32: data width.
- `HOLD_CYCLES`, default 1: cycles `per_valid` is held per transfer. Legal range 1..15.
- `CNT_W`, default 8: width of the violation counter.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_req` in 1: secure request.
- `s_data` in DW: secure write data.
- `s_gnt` out 1: secure grant pulse.
- `ns_req` in 1: non-secure request.
- `ns_data` in DW: non-secure write data.
- `ns_gnt` out 1: non-secure grant pulse. This pulse also marks a completed rejection.
- `ns_err` out 1: non-secure request rejected by lock.
- `lock_set` in 1: set lock. Secure side only.
- `lock_clr` in 1: clear lock. Secure side only.
- `lock` out 1: current lock state.
- `per_valid` out 1: write strobe to peripheral.
- `per_data` out DW: data to peripheral.
- `per_ns` out 1: security tag to peripheral. 1 = non-secure origin, 0 = secure.
- `viol_count` out CNT_W: saturating count of rejected non-secure requests.

## Operation
- **Reset.** All outputs 0 and state IDLE. `last_ns` = 1, so secure wins the first tie.
- **States.**
  - IDLE: arbitrate.
  - XFER: drive the peripheral.
  - REJECT: complete a refused non-secure request.
- **IDLE arbitration** (on each edge with at least one request):
  - Only one requester active: that requester wins.
  - Both active, unlocked: round-robin. The winner is the side not served last.
  - Both active, locked: secure wins unconditionally.
- **Secure winner, or non-secure winner while unlocked:**
  - Capture the winner's data into `per_data`.
  - Set `per_ns` to the winner's origin.
  - Update `last_ns`.
  - Load the hold counter with HOLD_CYCLES-1.
  - Go to XFER.
- **Non-secure winner while locked:** go to REJECT. `per_data`, `per_ns` and `last_ns` are unchanged.
- **XFER:**
  - `per_valid` = 1 for all HOLD_CYCLES cycles.
  - The winner's gnt = 1 in the first XFER cycle only.
  - Return to IDLE when the hold counter reaches 0.
- **REJECT** (exactly one cycle):
  - `ns_gnt` = 1, `ns_err` = 1, `per_valid` = 0.
  - `viol_count` increments, saturating at 2^CNT_W-1.
  - Return to IDLE.
- **Requester contract.** Hold req and data stable until gnt is sampled. Deassert req on the edge that samples gnt.
- **Lock register.**
  - `lock_set` sets the lock and `lock_clr` clears it. Set wins if both are asserted.
  - Lock changes take effect at the next arbitration decision, never mid-XFER.
- **Tag outputs.** `per_data` and `per_ns` hold their last values outside XFER.
- **Reset mid-transfer.** The transfer is abandoned: `per_valid` drops, the counter and lock clear, and the state returns to IDLE.

## Timing
- **Latency.**
  - Request sampled at edge N → XFER/REJECT from cycle N+1.
  - gnt and `per_valid` are high during cycle N+1.
- **Throughput.** Back-to-back transfers cost HOLD_CYCLES+1 cycles each, since one IDLE cycle is inserted between them.
- **Registered outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.
- **Decision point.** Only the lock value registered before decision edge N affects decision N. A `lock_set` in the same cycle as a request does not apply to that request.

## Test plan
- **Single secure write.** Reset, then `s_req` = 1 with `s_data` = 0xA5A5_0001 → next cycle `s_gnt` = 1, `per_valid` = 1, `per_data` = 0xA5A5_0001, `per_ns` = 0.
- **Round-robin.** Both requesters held continuously, unlocked, HOLD_CYCLES = 1 → grant order S, NS, S, NS with `per_ns` = 0, 1, 0, 1. Grants are 2 cycles apart.
- **Lock reject.**
  - Pulse `lock_set`, then `ns_req` with 0xDEAD_BEEF → one cycle with `ns_gnt` = 1, `ns_err` = 1, `per_valid` = 0.
  - `per_data` unchanged and `viol_count` = 1.
  - Pulse `lock_clr`; the next `ns_req` → `per_valid` = 1, `per_ns` = 1.
- **Locked tie and saturation.**
  - Locked with both requesting → secure wins every decision.
  - With CNT_W = 2, five rejected non-secure requests → `viol_count` = 3.
- **Hold and mid-transfer reset.**
  - HOLD_CYCLES = 4 → `per_valid` high for exactly 4 cycles, with gnt only in the first.
  - Assert `rst_n` = 0 in the 2nd cycle → next cycle all outputs are 0 and `lock` = 0.
